// File: rtl/ifid_stage.sv
// IF/ID pipeline stage: valid/ready handshake, 1- or 2-entry skid buffer,
// synchronous flush and a saturating stall counter. Fields are decoded on write.
module ifid_stage #(
    parameter int          PC_W      = 32,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc_inc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  PCinc,
    output logic [31:0]      instruction,
    output logic [5:0]       opCode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      constant,
    output logic [31:0]      imm_sext,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      op;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [15:0]     constant;
        logic [31:0]     imm_sext;
    } entry_t;

    function automatic entry_t decode(input logic [PC_W-1:0] pc, input logic [31:0] ins);
        entry_t e;
        e.pc       = pc;
        e.instr    = ins;
        e.op       = ins[31:26];
        e.rs       = ins[25:21];
        e.rt       = ins[20:16];
        e.rd       = ins[15:11];
        e.shamt    = ins[10:6];
        e.funct    = ins[5:0];
        e.constant = ins[15:0];
        e.imm_sext = {{16{ins[15]}}, ins[15:0]};
        return e;
    endfunction

    logic [1:0]       count_q, count_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    entry_t           incoming;
    entry_t           nop_entry;
    entry_t           out_entry;
    logic             ready_raw;
    logic             push;
    logic             pop;

    assign out_valid = (count_q != 2'd0);

    generate
        if (DEPTH == 1) begin : g_single
            // Single register: a pop frees the slot in the same cycle.
            assign ready_raw = !out_valid || out_ready;
        end else begin : g_skid
            // Skid buffer: readiness depends on occupancy only.
            assign ready_raw = (count_q < 2'd2);
        end
    endgenerate

    assign in_ready = rst_n && ready_raw;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        incoming = decode(in_pc_inc, in_instr);
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = incoming;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = incoming;
                    end else if (push) begin
                        tail_d  = incoming;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            stall_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
        end
    end

    // Empty stage presents the decoded NOP with a zero PC.
    always_comb begin
        nop_entry = decode(PC_W'(0), NOP_INSTR);
        out_entry = out_valid ? head_q : nop_entry;
    end

    assign PCinc       = out_entry.pc;
    assign instruction = out_entry.instr;
    assign opCode      = out_entry.op;
    assign rs          = out_entry.rs;
    assign rt          = out_entry.rt;
    assign rd          = out_entry.rd;
    assign shamt       = out_entry.shamt;
    assign funct       = out_entry.funct;
    assign constant    = out_entry.constant;
    assign imm_sext    = out_entry.imm_sext;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_ifid_stage.sv
// Randomised scoreboard bench for ifid_stage: a 2-deep/16-bit-counter instance
// and a 1-deep/4-bit-counter instance share stimulus, each against a FIFO model.
module tb_ifid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_pc_inc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        ready_w [2];
    logic        valid_w [2];
    logic [31:0] pcinc_w [2];
    logic [31:0] instr_w [2];
    logic [5:0]  op_w    [2];
    logic [4:0]  rs_w    [2];
    logic [4:0]  rt_w    [2];
    logic [4:0]  rd_w    [2];
    logic [4:0]  sh_w    [2];
    logic [5:0]  fn_w    [2];
    logic [15:0] cst_w   [2];
    logic [31:0] imm_w   [2];
    logic [15:0] stall0;
    logic [3:0]  stall1;
    logic [31:0] sw      [2];

    localparam logic [31:0] NOP1 = 32'h0000_0020;

    always #5 clk = ~clk;

    ifid_stage #(.PC_W(32), .DEPTH(2), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_w[0]),
        .in_pc_inc(in_pc_inc), .in_instr(in_instr), .flush(flush),
        .out_valid(valid_w[0]), .out_ready(out_ready), .PCinc(pcinc_w[0]),
        .instruction(instr_w[0]), .opCode(op_w[0]), .rs(rs_w[0]), .rt(rt_w[0]),
        .rd(rd_w[0]), .shamt(sh_w[0]), .funct(fn_w[0]), .constant(cst_w[0]),
        .imm_sext(imm_w[0]), .stall_cnt(stall0)
    );

    ifid_stage #(.PC_W(32), .DEPTH(1), .NOP_INSTR(NOP1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_w[1]),
        .in_pc_inc(in_pc_inc), .in_instr(in_instr), .flush(flush),
        .out_valid(valid_w[1]), .out_ready(out_ready), .PCinc(pcinc_w[1]),
        .instruction(instr_w[1]), .opCode(op_w[1]), .rs(rs_w[1]), .rt(rt_w[1]),
        .rd(rd_w[1]), .shamt(sh_w[1]), .funct(fn_w[1]), .constant(cst_w[1]),
        .imm_sext(imm_w[1]), .stall_cnt(stall1)
    );

    assign sw[0] = 32'(stall0);
    assign sw[1] = 32'(stall1);

    // Reference model: an ordered list of accepted entries per instance.
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          checking = 1'b0;
    int          mcnt   [2] = '{0, 0};
    int          mstall [2] = '{0, 0};
    int          smax   [2] = '{65535, 15};
    int          cap    [2] = '{2, 1};
    logic [31:0] nop    [2] = '{32'h0000_0000, NOP1};
    logic [31:0] mpc    [2][2];
    logic [31:0] minstr [2][2];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        er, ev, push, pop;
        logic [31:0] ei, ep, eimm;
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                ev = (mcnt[i] > 0);
                if (cap[i] == 2) er = rst_n && (mcnt[i] < 2);
                else             er = rst_n && (mcnt[i] == 0 || out_ready);
                ei   = ev ? minstr[i][0] : nop[i];
                ep   = ev ? mpc[i][0] : 32'h0;
                eimm = ((ei & 32'h8000) != 0) ? (ei | 32'hFFFF_0000) : (ei & 32'h0000_FFFF);
                chk("in_ready",    i, 32'(ready_w[i]), 32'(er));
                chk("out_valid",   i, 32'(valid_w[i]), 32'(ev));
                chk("PCinc",       i, pcinc_w[i], ep);
                chk("instruction", i, instr_w[i], ei);
                chk("opCode",      i, 32'(op_w[i]),  ei / 32'h0400_0000);
                chk("rs",          i, 32'(rs_w[i]),  (ei / 32'h20_0000) % 32);
                chk("rt",          i, 32'(rt_w[i]),  (ei / 32'h1_0000) % 32);
                chk("rd",          i, 32'(rd_w[i]),  (ei / 32'h800) % 32);
                chk("shamt",       i, 32'(sh_w[i]),  (ei / 64) % 32);
                chk("funct",       i, 32'(fn_w[i]),  ei % 64);
                chk("constant",    i, 32'(cst_w[i]), ei % 32'h1_0000);
                chk("imm_sext",    i, imm_w[i], eimm);
                chk("stall_cnt",   i, sw[i], 32'(mstall[i]));

                // Advance the model to the state after the coming rising edge.
                if (!rst_n) begin
                    mcnt[i]   = 0;
                    mstall[i] = 0;
                end else begin
                    push = in_valid && er;
                    pop  = ev && out_ready;
                    if (ev && !out_ready && mstall[i] < smax[i]) mstall[i]++;
                    if (flush) begin
                        mcnt[i] = 0;
                    end else begin
                        if (pop) begin
                            $display("t=%0t dut%0d pop pc=%h instr=%h", $time, i, mpc[i][0], minstr[i][0]);
                            mpc[i][0]    = mpc[i][1];
                            minstr[i][0] = minstr[i][1];
                            mcnt[i]--;
                        end
                        if (push) begin
                            mpc[i][mcnt[i]]    = in_pc_inc;
                            minstr[i][mcnt[i]] = in_instr;
                            mcnt[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic f, input logic r);
        in_valid  = v;
        in_pc_inc = pc;
        in_instr  = ins;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_pc_inc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        cyc(1, 32'h100, 32'h1234_5678, 0, 1);   // held in reset: not accepted
        rst_n = 1'b1;

        // lw decode
        cyc(1, 32'h0000_0004, 32'h8C22_0010, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // four-instruction stream at full rate
        for (int k = 0; k < 4; k++) cyc(1, 32'h8 + 32'(4 * k), 32'h0022_1820 + 32'(k), 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // back-pressure: A, B, C with decode stalled, then release
        cyc(1, 32'hA0, 32'h2001_0001, 0, 0);
        cyc(1, 32'hA4, 32'h2002_0002, 0, 0);
        repeat (3) cyc(1, 32'hA8, 32'h2003_0003, 0, 0);
        repeat (2) cyc(1, 32'hA8, 32'h2003_0003, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // negative immediate
        cyc(1, 32'hB0, 32'hFFFF_8000, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // flush while full with an incoming entry
        cyc(1, 32'hC0, 32'h3C01_0001, 0, 0);
        cyc(1, 32'hC4, 32'h3C02_0002, 0, 0);
        cyc(1, 32'hC8, 32'h3C03_0003, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // out_ready toggling
        for (int k = 0; k < 12; k++) cyc(1, 32'hD0 + 32'(4 * k), 32'h0100_0000 + 32'(k), 0, (k % 2) == 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // long stall: 4-bit counter saturates at 15
        cyc(1, 32'hE0, 32'h0000_0000, 0, 0);
        repeat (22) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // randomised traffic with occasional flush and reset
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(($urandom_range(0, 3) != 0), $urandom, $urandom,
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;
        repeat (4) cyc(0, 0, 0, 0, 1);
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
